// File: rtl/matrix_tile_scheduler_pkg.sv
// Shared types for the MAC-array tile scheduler: BRAM address types, the
// controller command word, the whole-matrix job descriptor and FSM states.
package matrix_tile_scheduler_pkg;

  localparam int JOB_TILE_CNT_W      = 8;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int BRAM_ADDR_W         = 16;
  localparam int LINE_SIZE_W         = 12;
  localparam int MATRIX_K_W          = 12;

  typedef logic [BRAM_ADDR_W-1:0] bram_addr_t;
  typedef logic [LINE_SIZE_W-1:0] line_size_t;

  typedef struct packed {
    logic                  valid;
    bram_addr_t            input_a_addr_begin;
    bram_addr_t            input_b_addr_begin;
    bram_addr_t            output_c_addr_begin;
    line_size_t            a_line_size;
    line_size_t            b_line_size;
    line_size_t            c_line_size;
    logic [MATRIX_K_W-1:0] matrix_n;
  } matrix_mul_ctrl_t;

  typedef struct packed {
    bram_addr_t                a_base;
    bram_addr_t                b_base;
    bram_addr_t                c_base;
    bram_addr_t                a_tile_step;
    bram_addr_t                b_tile_step;
    bram_addr_t                c_row_step;
    bram_addr_t                c_col_step;
    line_size_t                a_line_size;
    line_size_t                b_line_size;
    line_size_t                c_line_size;
    logic [MATRIX_K_W-1:0]     k;
    logic [JOB_TILE_CNT_W-1:0] tiles_m;
    logic [JOB_TILE_CNT_W-1:0] tiles_n;
  } tile_job_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_DRAIN = 2'd2
  } sched_state_e;

  // A job with no tiles or no reduction depth produces no commands at all.
  function automatic logic is_empty_job(input tile_job_t j);
    return (j.tiles_m == '0) || (j.tiles_n == '0) || (j.k == '0);
  endfunction

endpackage

// File: rtl/matrix_tile_scheduler_tile_addr_walker.sv
// tile_addr_walker: walks tile indices n-inner / m-outer and keeps the tile
// base addresses with running adders (no multipliers). All sums wrap at the
// BRAM address width.
module tile_addr_walker
  import matrix_tile_scheduler_pkg::*;
#(
  parameter int TILE_CNT_W = JOB_TILE_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  bram_addr_t            a_base_i,
  input  bram_addr_t            b_base_i,
  input  bram_addr_t            c_base_i,
  input  bram_addr_t            a_step_i,
  input  bram_addr_t            b_step_i,
  input  bram_addr_t            c_row_step_i,
  input  bram_addr_t            c_col_step_i,
  input  logic [TILE_CNT_W-1:0] tiles_m_i,
  input  logic [TILE_CNT_W-1:0] tiles_n_i,
  output bram_addr_t            a_addr_o,
  output bram_addr_t            b_addr_o,
  output bram_addr_t            c_addr_o,
  output logic                  last_o
);

  logic [TILE_CNT_W-1:0] m_q, n_q, m_last_q, n_last_q;
  bram_addr_t b_base_q, a_step_q, b_step_q, c_row_step_q, c_col_step_q;
  bram_addr_t a_q, b_q, c_q, c_row_q;

  // Load the walk on job accept, advance one tile per accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q          <= '0;
      n_q          <= '0;
      m_last_q     <= '0;
      n_last_q     <= '0;
      b_base_q     <= '0;
      a_step_q     <= '0;
      b_step_q     <= '0;
      c_row_step_q <= '0;
      c_col_step_q <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      c_row_q      <= '0;
    end else if (load_i) begin
      m_q          <= '0;
      n_q          <= '0;
      m_last_q     <= tiles_m_i - 1'b1;
      n_last_q     <= tiles_n_i - 1'b1;
      b_base_q     <= b_base_i;
      a_step_q     <= a_step_i;
      b_step_q     <= b_step_i;
      c_row_step_q <= c_row_step_i;
      c_col_step_q <= c_col_step_i;
      a_q          <= a_base_i;
      b_q          <= b_base_i;
      c_q          <= c_base_i;
      c_row_q      <= c_base_i;
    end else if (step_i) begin
      if (n_q == n_last_q) begin
        // Row wrap: C restarts from the next row base, B from its base.
        n_q     <= '0;
        m_q     <= m_q + 1'b1;
        a_q     <= a_q + a_step_q;
        b_q     <= b_base_q;
        c_row_q <= c_row_q + c_row_step_q;
        c_q     <= c_row_q + c_row_step_q;
      end else begin
        n_q <= n_q + 1'b1;
        b_q <= b_q + b_step_q;
        c_q <= c_q + c_col_step_q;
      end
    end
  end

  assign a_addr_o = a_q;
  assign b_addr_o = b_q;
  assign c_addr_o = c_q;
  assign last_o   = (m_q == m_last_q) && (n_q == n_last_q);

endmodule

// File: rtl/matrix_tile_scheduler.sv
// matrix_tile_scheduler: accepts one whole-matrix job and offers one
// matrix_mul_ctrl_t command per output tile, keeping at most MAX_OUTSTANDING
// tiles between accept and tile_done.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   SCHED_IDLE  | job_ready high, waiting for a descriptor
//   SCHED_ISSUE | offering tile commands while the outstanding window allows
//   SCHED_DRAIN | all tiles accepted, waiting for remaining completions
module matrix_tile_scheduler
  import matrix_tile_scheduler_pkg::*;
#(
  parameter int TILE_CNT_W      = JOB_TILE_CNT_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  tile_job_t        job,
  output matrix_mul_ctrl_t cmd,
  input  logic             cmd_req_valid,
  input  logic             tile_done,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int OUTS_W = $clog2(MAX_OUTSTANDING + 1);

  sched_state_e          state_q, state_d;
  logic [OUTS_W-1:0]     outs_q, outs_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  line_size_t            a_line_q, b_line_q, c_line_q;
  logic [MATRIX_K_W-1:0] k_q;

  logic       cmd_valid, accept, job_acc, last_tile;
  bram_addr_t a_addr, b_addr, c_addr;

  assign job_acc   = (state_q == SCHED_IDLE) && job_valid;
  assign cmd_valid = (state_q == SCHED_ISSUE) && (outs_q < OUTS_W'(MAX_OUTSTANDING));
  assign accept    = cmd_valid && cmd_req_valid;

  tile_addr_walker #(
    .TILE_CNT_W(TILE_CNT_W)
  ) u_walker (
    .clk          (clk),
    .rst          (rst),
    .load_i       (job_acc && !is_empty_job(job)),
    .step_i       (accept && !last_tile),
    .a_base_i     (job.a_base),
    .b_base_i     (job.b_base),
    .c_base_i     (job.c_base),
    .a_step_i     (job.a_tile_step),
    .b_step_i     (job.b_tile_step),
    .c_row_step_i (job.c_row_step),
    .c_col_step_i (job.c_col_step),
    .tiles_m_i    (job.tiles_m),
    .tiles_n_i    (job.tiles_n),
    .a_addr_o     (a_addr),
    .b_addr_o     (b_addr),
    .c_addr_o     (c_addr),
    .last_o       (last_tile)
  );

  // Next-state for FSM, outstanding window, error flag and done pulse.
  always_comb begin
    state_d = state_q;
    outs_d  = outs_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (job_acc) err_d = 1'b0;

    // An accept and a completion in the same cycle cancel out.
    if (accept && !tile_done) begin
      outs_d = outs_q + 1'b1;
    end else if (tile_done && !accept) begin
      if (outs_q == '0) err_d = 1'b1;
      else              outs_d = outs_q - 1'b1;
    end

    case (state_q)
      SCHED_IDLE: begin
        if (job_valid) begin
          if (is_empty_job(job)) done_d  = 1'b1;
          else                   state_d = SCHED_ISSUE;
        end
      end
      SCHED_ISSUE: begin
        if (accept && last_tile) begin
          if (outs_d == '0) begin
            state_d = SCHED_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SCHED_DRAIN;
          end
        end
      end
      SCHED_DRAIN: begin
        if (outs_d == '0) begin
          state_d = SCHED_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  // State registers; job-wide fields are latched on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCHED_IDLE;
      outs_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      a_line_q <= '0;
      b_line_q <= '0;
      c_line_q <= '0;
      k_q      <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (job_acc) begin
        a_line_q <= job.a_line_size;
        b_line_q <= job.b_line_size;
        c_line_q <= job.c_line_size;
        k_q      <= job.k;
      end
    end
  end

  // Command word: registered fields, offer computed from registered state.
  always_comb begin
    cmd                     = '0;
    cmd.valid               = cmd_valid;
    cmd.input_a_addr_begin  = a_addr;
    cmd.input_b_addr_begin  = b_addr;
    cmd.output_c_addr_begin = c_addr;
    cmd.a_line_size         = a_line_q;
    cmd.b_line_size         = b_line_q;
    cmd.c_line_size         = c_line_q;
    cmd.matrix_n            = k_q;
  end

  assign job_ready = (state_q == SCHED_IDLE);
  assign busy      = (state_q != SCHED_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_matrix_tile_scheduler.sv
// Testbench for matrix_tile_scheduler: directed scenarios plus random jobs,
// checked every cycle against a tile-list / outstanding-count model.
module tb_matrix_tile_scheduler;
  import matrix_tile_scheduler_pkg::*;

  localparam int MAXO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  tile_job_t        job;
  matrix_mul_ctrl_t cmd;
  logic             cmd_req_valid;
  logic             tile_done;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  matrix_tile_scheduler #(
    .TILE_CNT_W      (8),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job           (job),
    .cmd           (cmd),
    .cmd_req_valid (cmd_req_valid),
    .tile_done     (tile_done),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model
  bit         active, done_exp, err_exp;
  int         issued, total, outs;
  tile_job_t  cur;
  bram_addr_t exp_a[$], exp_b[$], exp_c[$];
  int         dq[$];
  int         req_mode, req_pct, wait_cnt, done_delay;
  int         dut_acc_cnt, done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit model_valid();
    return active && (issued < total) && (outs < MAXO);
  endfunction

  task automatic check_outputs();
    bit v;
    v = model_valid();
    chk("cmd_valid", 32'(cmd.valid), 32'(v));
    if (v) begin
      chk("cmd_a_addr", 32'(cmd.input_a_addr_begin), 32'(exp_a[issued]));
      chk("cmd_b_addr", 32'(cmd.input_b_addr_begin), 32'(exp_b[issued]));
      chk("cmd_c_addr", 32'(cmd.output_c_addr_begin), 32'(exp_c[issued]));
      chk("cmd_a_line", 32'(cmd.a_line_size), 32'(cur.a_line_size));
      chk("cmd_b_line", 32'(cmd.b_line_size), 32'(cur.b_line_size));
      chk("cmd_c_line", 32'(cmd.c_line_size), 32'(cur.c_line_size));
      chk("cmd_matrix_n", 32'(cmd.matrix_n), 32'(cur.k));
    end
    chk("done", 32'(done), 32'(done_exp));
    chk("busy", 32'(busy), 32'(active));
    chk("job_ready", 32'(job_ready), 32'(!active));
    chk("err", 32'(err), 32'(err_exp));
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic check_reset_fields();
    chk("rst_cmd_valid", 32'(cmd.valid), 32'(0));
    chk("rst_a_addr", 32'(cmd.input_a_addr_begin), 32'(0));
    chk("rst_b_addr", 32'(cmd.input_b_addr_begin), 32'(0));
    chk("rst_c_addr", 32'(cmd.output_c_addr_begin), 32'(0));
    chk("rst_lines", 32'({cmd.a_line_size, cmd.b_line_size}), 32'(0));
    chk("rst_c_line", 32'(cmd.c_line_size), 32'(0));
    chk("rst_matrix_n", 32'(cmd.matrix_n), 32'(0));
    chk("rst_job_ready", 32'(job_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
  endtask

  task automatic cycle();
    bit req, td, acc, v;
    check_outputs();
    v = model_valid();
    case (req_mode)
      0:       req = 1'b1;
      1:       req = (wait_cnt >= 5);
      default: req = ($urandom_range(99) < req_pct);
    endcase
    td = 1'b0;
    if (dq.size() > 0 && dq[0] <= cyc) begin
      td = 1'b1;
      void'(dq.pop_front());
    end
    acc = v && req;
    if (cmd.valid === 1'b1 && req) dut_acc_cnt++;
    if (acc) wait_cnt = 0;
    else if (v) wait_cnt++;
    done_exp = 1'b0;
    if (acc) begin
      issued++;
      if (done_delay > 0) dq.push_back(cyc + done_delay);
    end
    if (acc && !td) outs++;
    else if (td && !acc) begin
      if (outs == 0) err_exp = 1'b1;
      else outs--;
    end
    if (active && issued == total && outs == 0) begin
      active   = 1'b0;
      done_exp = 1'b1;
    end
    cmd_req_valid = req;
    tile_done     = td;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_job(input tile_job_t j);
    check_outputs();
    cur = j;
    exp_a.delete();
    exp_b.delete();
    exp_c.delete();
    for (int m = 0; m < int'(j.tiles_m); m++) begin
      for (int n = 0; n < int'(j.tiles_n); n++) begin
        exp_a.push_back(j.a_base + bram_addr_t'(m) * j.a_tile_step);
        exp_b.push_back(j.b_base + bram_addr_t'(n) * j.b_tile_step);
        exp_c.push_back(j.c_base + bram_addr_t'(m) * j.c_row_step + bram_addr_t'(n) * j.c_col_step);
      end
    end
    total       = (j.k == '0) ? 0 : int'(j.tiles_m) * int'(j.tiles_n);
    issued      = 0;
    outs        = 0;
    err_exp     = 1'b0;
    done_exp    = (total == 0);
    active      = (total != 0);
    wait_cnt    = 0;
    dut_acc_cnt = 0;
    done_cnt    = 0;
    dq.delete();
    job           = j;
    job_valid     = 1'b1;
    cmd_req_valid = 1'b0;
    tile_done     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    job_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((active || done_exp) && n < budget) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    chk("job_ready_after_job", 32'(job_ready), 32'(1));
    chk("busy_after_job", 32'(busy), 32'(0));
    chk("done_pulse_count", 32'(done_cnt), 32'(1));
  endtask

  function automatic tile_job_t base_job();
    tile_job_t j;
    j             = '0;
    j.a_base      = 16'h0010;
    j.a_tile_step = 16'h0040;
    j.b_base      = 16'h0200;
    j.b_tile_step = 16'h0008;
    j.c_base      = 16'h1000;
    j.c_row_step  = 16'h0100;
    j.c_col_step  = 16'h0008;
    j.a_line_size = 12'h020;
    j.b_line_size = 12'h030;
    j.c_line_size = 12'h040;
    j.k           = 12'd16;
    j.tiles_m     = 8'd2;
    j.tiles_n     = 8'd3;
    return j;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_job_t j;
    rst           = 1'b1;
    job_valid     = 1'b0;
    job           = '0;
    cmd_req_valid = 1'b0;
    tile_done     = 1'b0;
    active        = 1'b0;
    done_exp      = 1'b0;
    err_exp       = 1'b0;
    issued        = 0;
    total         = 0;
    outs          = 0;
    req_mode      = 0;
    req_pct       = 100;
    done_delay    = 20;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_fields();
    rst = 1'b0;
    cycle();

    // Always-ready controller, completions 20 cycles after each accept
    req_mode = 0; done_delay = 20;
    start_job(base_job());
    run_until_idle(400);

    // Controller holds off 5 cycles per command
    req_mode = 1; done_delay = 20;
    start_job(base_job());
    run_until_idle(600);

    // Completions withheld: window closes after 4 accepts
    req_mode = 0; done_delay = 0;
    start_job(base_job());
    repeat (12) cycle();
    chk("stall_after_window", 32'(dut_acc_cnt), 32'(4));
    dq.push_back(cyc);
    repeat (8) cycle();
    chk("one_more_accept", 32'(dut_acc_cnt), 32'(5));
    done_delay = 3;
    for (int i = 0; i < outs; i++) dq.push_back(cyc + i);
    run_until_idle(200);

    // Empty jobs: tiles_n = 0, then k = 0
    j = base_job(); j.tiles_n = 8'd0;
    start_job(j);
    run_until_idle(20);
    j = base_job(); j.k = 12'd0;
    start_job(j);
    run_until_idle(20);

    // Completion lands in the same cycle as the last accept
    req_mode = 0; done_delay = 5;
    start_job(base_job());
    run_until_idle(200);

    // Reset during ISSUE after two accepts
    req_mode = 0; done_delay = 20;
    start_job(base_job());
    cycle();
    cycle();
    rst           = 1'b1;
    cmd_req_valid = 1'b0;
    tile_done     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    active = 1'b0; done_exp = 1'b0; err_exp = 1'b0;
    issued = 0; outs = 0; total = 0;
    dq.delete();
    check_reset_fields();
    rst = 1'b0;
    repeat (3) cycle();
    start_job(base_job());
    run_until_idle(400);

    // Stray completion with nothing outstanding sets err until next job
    dq.push_back(cyc);
    repeat (4) cycle();
    chk("err_sticky", 32'(err), 32'(1));

    // Random jobs with random back-pressure and completion latency
    for (int it = 0; it < 6; it++) begin
      j             = '0;
      j.a_base      = bram_addr_t'($urandom);
      j.b_base      = bram_addr_t'($urandom);
      j.c_base      = bram_addr_t'($urandom);
      j.a_tile_step = bram_addr_t'($urandom);
      j.b_tile_step = bram_addr_t'($urandom);
      j.c_row_step  = bram_addr_t'($urandom);
      j.c_col_step  = bram_addr_t'($urandom);
      j.a_line_size = line_size_t'($urandom);
      j.b_line_size = line_size_t'($urandom);
      j.c_line_size = line_size_t'($urandom);
      j.k           = 12'($urandom_range(4095, 1));
      j.tiles_m     = 8'($urandom_range(3, 1));
      j.tiles_n     = 8'($urandom_range(3, 1));
      req_mode      = 2;
      req_pct       = int'($urandom_range(90, 30));
      done_delay    = int'($urandom_range(25, 1));
      start_job(j);
      run_until_idle(2000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
